// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-state engine.
package pong_pkg;

  localparam int unsigned GRID    = 32;
  localparam int unsigned COORD_W = 5;
  localparam int unsigned COLOR_W = 6;

  localparam logic [COORD_W-1:0] CENTER = 5'd15;

  localparam logic [COLOR_W-1:0] BG_COLOR_DEF   = 6'b000010;
  localparam logic [COLOR_W-1:0] MISS_COLOR_DEF = 6'b110000;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } state_e;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: saturating per-frame up/down position and its registered row-occupancy mask.
module pong_paddle
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_LEN = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame,
  input  logic               up,
  input  logic               dn,
  output logic [COORD_W-1:0] pos,
  output logic [GRID-1:0]    mask
);

  localparam logic [COORD_W-1:0] POS_MAX   = COORD_W'(GRID - PADDLE_LEN);
  localparam logic [COORD_W-1:0] POS_INIT  = COORD_W'((GRID - PADDLE_LEN) / 2);
  localparam logic [GRID-1:0]    MASK_BASE = GRID'((64'd1 << PADDLE_LEN) - 64'd1);
  localparam logic [GRID-1:0]    MASK_INIT = MASK_BASE << POS_INIT;

  logic [COORD_W-1:0] pos_q, pos_d;
  logic [GRID-1:0]    mask_q, mask_d;

  // Opposing or absent presses hold the paddle still.
  always_comb begin
    pos_d = pos_q;
    if (frame) begin
      if (up && !dn && (pos_q != '0)) begin
        pos_d = pos_q - COORD_W'(1);
      end else if (dn && !up && (pos_q != POS_MAX)) begin
        pos_d = pos_q + COORD_W'(1);
      end
    end
    mask_d = MASK_BASE << pos_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q  <= POS_INIT;
      mask_q <= MASK_INIT;
    end else begin
      pos_q  <= pos_d;
      mask_q <= mask_d;
    end
  end

  assign pos  = pos_q;
  assign mask = mask_q;

endmodule

// File: rtl/pong_game.sv
// Per-frame pong game state: serve/play/miss sequencing, ball motion, scoring, background.
// Define PONG_AUTOPLAY_EN to have the right paddle track the ball instead of its buttons.
module pong_game
  import pong_pkg::*;
#(
  parameter int unsigned        PADDLE_LEN   = 5,
  parameter int unsigned        BALL_DIV     = 2,
  parameter int unsigned        SERVE_FRAMES = 32,
  parameter int unsigned        MISS_FRAMES  = 16,
  parameter logic [COLOR_W-1:0] BG_COLOR     = BG_COLOR_DEF,
  parameter logic [COLOR_W-1:0] MISS_COLOR   = MISS_COLOR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame,
  input  logic               lbtn_up,
  input  logic               lbtn_dn,
  input  logic               rbtn_up,
  input  logic               rbtn_dn,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [GRID-1:0]    lpaddle,
  output logic [GRID-1:0]    rpaddle,
  output logic [COLOR_W-1:0] bgcolor,
  output logic [3:0]         lscore,
  output logic [3:0]         rscore
);

  localparam int unsigned CNT_W = 8;
  localparam logic [COORD_W-1:0] X_LEDGE = COORD_W'(GRID - 2);
  localparam logic [COORD_W-1:0] X_LGOAL = COORD_W'(GRID - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               dx_q, dx_d, dy_q, dy_d;
  logic [3:0]         ls_q, ls_d, rs_q, rs_d;
  logic [COLOR_W-1:0] bg_q, bg_d;

  logic [COORD_W-1:0] lpos, rpos;
  logic [GRID-1:0]    lmask, rmask;
  logic               r_up, r_dn;
  logic               unused_pos;
  logic               ny_dir;
  logic [COORD_W-1:0] ny;

  assign unused_pos = ^{lpos, rpos};

`ifdef PONG_AUTOPLAY_EN
  // Steer the right paddle's centre row toward the ball row.
  assign r_up = (y_q < (rpos + COORD_W'(PADDLE_LEN / 2)));
  assign r_dn = (y_q > (rpos + COORD_W'(PADDLE_LEN / 2)));
`else
  assign r_up = rbtn_up;
  assign r_dn = rbtn_dn;
`endif

  pong_paddle #(.PADDLE_LEN(PADDLE_LEN)) u_lpaddle (
    .clk   (clk),
    .reset (reset),
    .frame (frame),
    .up    (lbtn_up),
    .dn    (lbtn_dn),
    .pos   (lpos),
    .mask  (lmask)
  );

  pong_paddle #(.PADDLE_LEN(PADDLE_LEN)) u_rpaddle (
    .clk   (clk),
    .reset (reset),
    .frame (frame),
    .up    (r_up),
    .dn    (r_dn),
    .pos   (rpos),
    .mask  (rmask)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    ls_d    = ls_q;
    rs_d    = rs_q;
    bg_d    = bg_q;
    ny_dir  = dy_q;
    ny      = y_q;
    if (frame) begin
      unique case (state_q)
        SERVE: begin
          x_d = CENTER;
          y_d = CENTER;
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PLAY: begin
          if (cnt_q == CNT_W'(BALL_DIV - 1)) begin
            cnt_d = '0;
            // Wall bounce resolves before the move; paddle test uses the moved row.
            if ((y_q == '0) && !dy_q)   ny_dir = 1'b1;
            if ((y_q == Y_MAX) && dy_q) ny_dir = 1'b0;
            ny   = ny_dir ? (y_q + COORD_W'(1)) : (y_q - COORD_W'(1));
            dy_d = ny_dir;
            y_d  = ny;
            if ((x_q == X_LEDGE) && dx_q) begin
              if (lmask[ny]) begin
                dx_d = 1'b0;
                x_d  = X_LEDGE - COORD_W'(1);
              end else begin
                x_d     = X_LGOAL;
                rs_d    = (rs_q == 4'd9) ? 4'd0 : (rs_q + 4'd1);
                state_d = MISS;
              end
            end else if ((x_q == COORD_W'(1)) && !dx_q) begin
              if (rmask[ny]) begin
                dx_d = 1'b1;
                x_d  = COORD_W'(2);
              end else begin
                x_d     = '0;
                ls_d    = (ls_q == 4'd9) ? 4'd0 : (ls_q + 4'd1);
                state_d = MISS;
              end
            end else begin
              x_d = dx_q ? (x_q + COORD_W'(1)) : (x_q - COORD_W'(1));
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MISS: begin
          if (cnt_q == CNT_W'(MISS_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = SERVE;
            x_d     = CENTER;
            y_d     = CENTER;
            dx_d    = ~dx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = SERVE;
        end
      endcase
      bg_d = (state_d == MISS) ? MISS_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SERVE;
      cnt_q   <= '0;
      x_q     <= CENTER;
      y_q     <= CENTER;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      ls_q    <= '0;
      rs_q    <= '0;
      bg_q    <= BG_COLOR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      ls_q    <= ls_d;
      rs_q    <= rs_d;
      bg_q    <= bg_d;
    end
  end

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign lpaddle = lmask;
  assign rpaddle = rmask;
  assign bgcolor = bg_q;
  assign lscore  = ls_q;
  assign rscore  = rs_q;

endmodule

// File: tb/tb_pong_game.sv
// Directed bench for pong_game: a scripted rally table plus reset, hold, serve-timing and score-wrap sequences.
module tb_pong_game;

  logic        clk    = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset;
  logic        frame;
  logic        lbtn_up, lbtn_dn, rbtn_up, rbtn_dn;
  logic [4:0]  ball_x, ball_y;
  logic [31:0] lpaddle, rpaddle;
  logic [5:0]  bgcolor;
  logic [3:0]  lscore, rscore;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [31:0] MID  = 32'h0003E000;
  localparam logic [31:0] TOP  = 32'h0000001F;
  localparam logic [31:0] BOT  = 32'hF8000000;
  localparam logic [5:0]  BG   = 6'b000010;
  localparam logic [5:0]  MISC = 6'b110000;

  typedef struct {
    logic        lu, ld, ru, rd;
    int          nfr;
    logic [4:0]  x, y;
    logic [31:0] lp, rp;
    logic [5:0]  bg;
    logic [3:0]  ls, rs;
  } vec_t;

  vec_t vt[15];

  pong_game dut (
    .clk     (clk),
    .reset   (reset),
    .frame   (frame),
    .lbtn_up (lbtn_up),
    .lbtn_dn (lbtn_dn),
    .rbtn_up (rbtn_up),
    .rbtn_dn (rbtn_dn),
    .ball_x  (ball_x),
    .ball_y  (ball_y),
    .lpaddle (lpaddle),
    .rpaddle (rpaddle),
    .bgcolor (bgcolor),
    .lscore  (lscore),
    .rscore  (rscore)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string nm, input logic [4:0] ex, input logic [4:0] ey,
                       input logic [31:0] elp, input logic [31:0] erp, input logic [5:0] ebg,
                       input logic [3:0] els, input logic [3:0] ers);
    n_vec++;
    if ({ball_x, ball_y, lpaddle, rpaddle, bgcolor, lscore, rscore} !==
        {ex, ey, elp, erp, ebg, els, ers}) begin
      n_bad++;
      $display("FAIL %s: got ball=(%0d,%0d) lp=%h rp=%h bg=%b ls=%0d rs=%0d, want ball=(%0d,%0d) lp=%h rp=%h bg=%b ls=%0d rs=%0d",
               nm, ball_x, ball_y, lpaddle, rpaddle, bgcolor, lscore, rscore,
               ex, ey, elp, erp, ebg, els, ers);
    end
  endtask

  task automatic set_btn(input logic lu, input logic ld, input logic ru, input logic rd);
    lbtn_up = lu;
    lbtn_dn = ld;
    rbtn_up = ru;
    rbtn_dn = rd;
  endtask

  // Entered and left at a falling edge; each frame pulse spans exactly one rising edge.
  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    frame = 1'b0;
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // lu ld ru rd, frames, x, y, lpaddle, rpaddle, bg, lscore, rscore
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,  0, 5'd15, 5'd15, MID, MID, BG,   4'd0, 4'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 20, 5'd15, 5'd15, TOP, MID, BG,   4'd0, 4'd0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 40, 5'd29, 5'd29, BOT, MID, BG,   4'd0, 4'd0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,  2, 5'd30, 5'd30, BOT, MID, BG,   4'd0, 4'd0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 5'd29, 5'd31, BOT, MID, BG,   4'd0, 4'd0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 5'd28, 5'd30, BOT, MID, BG,   4'd0, 4'd0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 54, 5'd1,  5'd3,  BOT, TOP, BG,   4'd0, 4'd0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 5'd2,  5'd2,  BOT, TOP, BG,   4'd0, 4'd0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0,  6, 5'd5,  5'd1,  BOT, TOP, BG,   4'd0, 4'd0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 50, 5'd30, 5'd26, TOP, TOP, BG,   4'd0, 4'd0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0,  2, 5'd31, 5'd27, TOP, TOP, MISC, 4'd0, 4'd1};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 15, 5'd31, 5'd27, TOP, TOP, MISC, 4'd0, 4'd1};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 5'd15, 5'd15, TOP, TOP, BG,   4'd0, 4'd1};
    vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 33, 5'd15, 5'd15, TOP, TOP, BG,   4'd0, 4'd1};
    vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0,  1, 5'd14, 5'd16, TOP, TOP, BG,   4'd0, 4'd1};

    do_reset();

`ifndef PONG_AUTOPLAY_EN
    for (int i = 0; i < 15; i++) begin
      set_btn(vt[i].lu, vt[i].ld, vt[i].ru, vt[i].rd);
      run_frames(vt[i].nfr);
      check($sformatf("rally_vec%0d", i), vt[i].x, vt[i].y, vt[i].lp, vt[i].rp,
            vt[i].bg, vt[i].ls, vt[i].rs);
    end
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
`else
    run_frames(40);
`endif

    // Asynchronous reset with the clock stopped mid-rally.
    clk_en = 1'b0;
    #20;
    reset = 1'b1;
    #2;
    check("async_reset", 5'd15, 5'd15, MID, MID, BG, 4'd0, 4'd0);
    reset = 1'b0;
    #2;
    clk_en = 1'b1;
    @(negedge clk);

    // Without a frame strobe nothing moves, even with every button held.
    set_btn(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("no_frame_hold", 5'd15, 5'd15, MID, MID, BG, 4'd0, 4'd0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);

    // First ball step lands on frame SERVE_FRAMES + BALL_DIV.
    run_frames(33);
    check("serve_f33", 5'd15, 5'd15, MID, MID, BG, 4'd0, 4'd0);
    run_frames(1);
    check("serve_f34", 5'd16, 5'd16, MID, MID, BG, 4'd0, 4'd0);

`ifndef PONG_AUTOPLAY_EN
    // Idle paddles: right-paddle miss at frame 64, left-paddle miss at 142, cycle repeats every 158.
    do_reset();
    run_frames(80);
    check("cycle_half", 5'd15, 5'd15, MID, MID, BG, 4'd0, 4'd1);
    run_frames(78);
    check("cycle_full", 5'd15, 5'd15, MID, MID, BG, 4'd1, 4'd1);
    for (int c = 2; c <= 9; c++) begin
      run_frames(158);
      check($sformatf("cycle%0d", c), 5'd15, 5'd15, MID, MID, BG, 4'(c), 4'(c));
    end
    run_frames(64);
    check("rscore_wrap", 5'd31, 5'd31, MID, MID, MISC, 4'd9, 4'd0);
    run_frames(78);
    check("lscore_wrap", 5'd0, 5'd30, MID, MID, MISC, 4'd0, 4'd0);
`else
    do_reset();
    for (int c = 0; c < 10; c++) begin
      run_frames(200);
      n_vec++;
      if (lscore !== 4'd0) begin
        n_bad++;
        $display("FAIL autoplay_chunk%0d: lscore got %0d want 0", c, lscore);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_game.md
Name: pong_game

Overview:
- Game-state engine that drives the playfield renderer directly downstream of it.
- Holds paddle positions, ball position/direction, scores and background colour.
- Advances state once per video frame on a one-cycle `frame` strobe (issued at start of vertical blank, so the renderer never sees a mid-frame change).
- Playfield is a 32x32 cell grid. The `lpaddle` player owns column 31; the `rpaddle` player owns column 0.

Parameters:
- PADDLE_LEN, 5, paddle height in cells (2..16).
- BALL_DIV, 2, frames per ball step (1..15).
- SERVE_FRAMES, 32, frames the ball rests at centre before a serve.
- MISS_FRAMES, 16, frames the miss colour is shown.
- BG_COLOR, 6'b000010, normal background (rrggbb).
- MISS_COLOR, 6'b110000, background during MISS.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-high
- frame  in  1  one-cycle pulse per frame
- lbtn_up  in  1  lpaddle player up (synchronous level)
- lbtn_dn  in  1  lpaddle player down
- rbtn_up  in  1  rpaddle player up
- rbtn_dn  in  1  rpaddle player down
- ball_x  out  5  ball column
- ball_y  out  5  ball row
- lpaddle  out  32  bit i set = column-31 cell at row i occupied
- rpaddle  out  32  bit i set = column-0 cell at row i occupied
- bgcolor  out  6  background colour
- lscore  out  4  lpaddle player score, 0..9
- rscore  out  4  rpaddle player score, 0..9

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Outputs: all registered. State changes only on a clk edge where `frame`=1; the new values are visible the next cycle. With `frame`=0 everything holds.
- Reset values:
  - FSM=SERVE, ball=(15,15), dx=+1, dy=+1.
  - Paddle top rows lpos=rpos=(32-PADDLE_LEN)/2, i.e. 13 at the default.
  - Scores 0, bgcolor=BG_COLOR, frame counter 0.
  - An assertion mid-frame or mid-serve abandons the rally immediately.
- Paddles (every frame, in every state):
  - up alone: pos-1, saturating at 0.
  - dn alone: pos+1, saturating at 32-PADDLE_LEN.
  - both or neither pressed: hold.
  - Mask = ((1<<PADDLE_LEN)-1) << pos, computed 32 bits wide.
- FSM SERVE:
  - Ball held at (15,15), bgcolor=BG_COLOR.
  - Counter runs to SERVE_FRAMES-1, then clears and goes to PLAY.
- FSM PLAY:
  - Step counter counts frames; the ball steps when it reaches BALL_DIV-1, then the counter clears.
  - Vertical first:
    - y==0 with dy=-1, or y==31 with dy=+1: dy flips before the move.
    - Then y += dy.
  - Horizontal, using the new y and the paddle masks from before this frame's paddle update:
    - x==30, dx=+1, lpaddle[new y]=1: dx becomes -1, x becomes 29.
    - x==30, dx=+1, lpaddle[new y]=0: x becomes 31, rscore increments (9 wraps to 0), go to MISS.
    - x==1, dx=-1: mirror image using rpaddle; on a miss x becomes 0 and lscore increments.
    - Otherwise x += dx.
  - A corner bounce and a paddle hit in the same step both apply.
- FSM MISS:
  - Ball frozen, bgcolor=MISS_COLOR.
  - After MISS_FRAMES frames: go to SERVE, ball to (15,15).
  - dx inverted (the ball serves toward the scorer), dy unchanged.
- All coordinate arithmetic is 5-bit. Wraparound is never permitted: the rules above prevent it.

Optional Feature:
- PONG_AUTOPLAY_EN defined:
  - rbtn_up/rbtn_dn are ignored.
  - Each frame, rpaddle moves one row toward centring on ball_y: up if ball_y < rpos+PADDLE_LEN/2, down if greater, same saturation rules.
- Undefined: the rpaddle is button-driven only and the tracking logic is absent.

Decomposition:
- Package pong_pkg:
  - state enum {SERVE, PLAY, MISS}.
  - GRID=32, CENTER=5'd15, colour constants.
- Sub-module pong_paddle, instantiated twice:
  - Inputs: clk, reset, frame, up, dn.
  - Outputs: pos[4:0] and mask[31:0].
  - The autoplay mux sits in front of the right instance.

Test Plan:
- Reset asserted mid-PLAY, clk stopped → ball (15,15), lpaddle=rpaddle=32'h0003E000, scores 0, bgcolor 6'b000010 without any clk edge.
- Hold lbtn_up 20 frames → lpaddle=32'h0000001F (saturated at 0). Hold lbtn_dn 40 frames → 32'hF8000000. Both pressed → no change.
- After reset, count frames → ball leaves (15,15) exactly at frame 32 + BALL_DIV.
- Ball at x=30, dx=+1, y=14→15, lpaddle covers rows 13..17 → next step x=29, no score change.
- Same with lpaddle at rows 0..4 → x=31, rscore=1, bgcolor=MISS_COLOR for 16 frames, then SERVE at (15,15) with dx=-1.
- Ball at (10,31), dy=+1 → next y=30. rscore=9 plus one more miss → rscore=0. With PONG_AUTOPLAY_EN, rpaddle never misses over 2000 frames.
